// File: rtl/tri_inv_nlats_rcv_fifo_if.sv
// Handshake and status bundle for the receive FIFO that sits behind an
// inverting latch bank. The master side is the upstream bank together with
// the downstream consumer. The slave side is the FIFO itself.
interface tri_inv_nlats_rcv_fifo_if #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
);

    logic [0:WIDTH-1]     din_b;
    logic                 din_val;
    logic                 din_rdy;
    logic [0:WIDTH-1]     dout;
    logic                 dout_val;
    logic                 dout_take;
    logic [0:CNT_WIDTH-1] count;
    logic                 ovf_err;
    logic                 udf_err;
    logic                 clr_err;

    modport master (
        output din_b, din_val, dout_take, clr_err,
        input  din_rdy, dout, dout_val, count, ovf_err, udf_err
    );

    modport slave (
        input  din_b, din_val, dout_take, clr_err,
        output din_rdy, dout, dout_val, count, ovf_err, udf_err
    );

endinterface

// File: rtl/tri_inv_nlats_rcv_fifo.sv
// Receive-side elastic buffer for an inverting latch bank.
// The FIFO takes active-low words, stores them in true polarity and presents
// the head word first-word-fall-through. It also keeps sticky
// overflow/underflow flags for the error-reporting logic.
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 4
`endif

module tri_inv_nlats_rcv_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic [0:`NCLK_WIDTH-1]       nclk,
    inout  wire                          vd,
    inout  wire                          gd,
    tri_inv_nlats_rcv_fifo_if.slave      bus
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    logic clk;
    logic rst;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [CNT_WIDTH-1:0] occ;
    logic                 rdy_en;
    logic                 ovf_q;
    logic                 udf_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic ovf_set;
    logic udf_set;

    // Power pins and spare clock-bus bits exist only for netlist compatibility.
    logic unused_pins;
    assign unused_pins = &{1'b0, vd, gd, nclk[2:`NCLK_WIDTH-1]};

    assign clk = nclk[0];
    assign rst = nclk[1];

    // Handshake qualifiers are decoded from registered state only.
    // rdy_en keeps din_rdy low through reset and for the cycle in which
    // reset releases.
    always_comb begin
        full    = (occ == FULL_COUNT);
        empty   = (occ == '0);
        push    = bus.din_val & rdy_en & ~full;
        pop     = bus.dout_take & ~empty;
        ovf_set = bus.din_val & full;
        udf_set = bus.dout_take & empty;
    end

    assign bus.din_rdy  = rdy_en & ~full;
    assign bus.dout_val = ~empty;
    assign bus.dout     = empty ? '0 : mem[rd_ptr];
    assign bus.count    = occ;
    assign bus.ovf_err  = ovf_q;
    assign bus.udf_err  = udf_q;

    // Storage array is deliberately not reset; it captures true polarity on push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ~bus.din_b;
        end
    end

    // Pointers, occupancy and ready enable, with asynchronous discard on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Sticky error flags. A new error in the same cycle overrides clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~bus.clr_err);
            udf_q <= udf_set | (udf_q & ~bus.clr_err);
        end
    end

endmodule

// File: tb/tb_tri_inv_nlats_rcv_fifo.sv
// Directed, table-driven bench for tri_inv_nlats_rcv_fifo (WIDTH=8, DEPTH=4).
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 4
`endif

module tb_tri_inv_nlats_rcv_fifo;

    typedef struct {
        logic [7:0] din_b;
        logic       din_val;
        logic       dout_take;
        logic       clr_err;
        logic [7:0] exp_dout;
        logic       exp_val;
        logic       exp_rdy;
        int         exp_count;
        logic       exp_ovf;
        logic       exp_udf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [0:`NCLK_WIDTH-1] nclk;
    wire vd = 1'b1;
    wire gd = 1'b0;

    int nvec = 0;
    int nfail = 0;
    vec_t vecs[$];

    tri_inv_nlats_rcv_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

    tri_inv_nlats_rcv_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .nclk (nclk),
        .vd   (vd),
        .gd   (gd),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        nclk    = '0;
        nclk[0] = clk;
        nclk[1] = rst;
    end

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int d, input int v, input int r,
                             input int c, input int o, input int u);
        check({tag, " dout"},     int'(bus.dout),     d);
        check({tag, " dout_val"}, int'(bus.dout_val), v);
        check({tag, " din_rdy"},  int'(bus.din_rdy),  r);
        check({tag, " count"},    int'(bus.count),    c);
        check({tag, " ovf_err"},  int'(bus.ovf_err),  o);
        check({tag, " udf_err"},  int'(bus.udf_err),  u);
    endtask

    task automatic add(input logic [7:0] db, input logic dv, input logic tk, input logic clr,
                       input logic [7:0] ed, input logic ev, input logic er, input int ec,
                       input logic eo, input logic eu);
        vec_t t;
        t.din_b = db; t.din_val = dv; t.dout_take = tk; t.clr_err = clr;
        t.exp_dout = ed; t.exp_val = ev; t.exp_rdy = er; t.exp_count = ec;
        t.exp_ovf = eo; t.exp_udf = eu;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic [7:0] db, input logic dv, input logic tk, input logic clr);
        @(negedge clk);
        bus.din_b     = db;
        bus.din_val   = dv;
        bus.dout_take = tk;
        bus.clr_err   = clr;
    endtask

    initial begin
        bus.din_b = 8'hFF; bus.din_val = 1'b0; bus.dout_take = 1'b0; bus.clr_err = 1'b0;

        //   din_b  val tk clr | dout  val rdy cnt ovf udf
        add(8'h00, 0, 0, 0,   8'h00, 0, 1, 0, 0, 0);  // idle after reset
        add(8'hF0, 1, 0, 0,   8'h0F, 1, 1, 1, 0, 0);  // single push, next-cycle visibility
        add(8'h00, 0, 0, 0,   8'h0F, 1, 1, 1, 0, 0);
        add(8'h00, 0, 1, 0,   8'h00, 0, 1, 0, 0, 0);
        add(8'hFE, 1, 0, 0,   8'h01, 1, 1, 1, 0, 0);  // fill to 4
        add(8'hFD, 1, 0, 0,   8'h01, 1, 1, 2, 0, 0);
        add(8'hFB, 1, 0, 0,   8'h01, 1, 1, 3, 0, 0);
        add(8'hF7, 1, 0, 0,   8'h01, 1, 0, 4, 0, 0);
        add(8'h00, 0, 1, 0,   8'h02, 1, 1, 3, 0, 0);  // drain in order
        add(8'h00, 0, 1, 0,   8'h04, 1, 1, 2, 0, 0);
        add(8'h00, 0, 1, 0,   8'h08, 1, 1, 1, 0, 0);
        add(8'h00, 0, 1, 0,   8'h00, 0, 1, 0, 0, 0);
        add(8'h00, 1, 0, 0,   8'hFF, 1, 1, 1, 0, 0);  // refill, pointers wrap
        add(8'h11, 1, 0, 0,   8'hFF, 1, 1, 2, 0, 0);
        add(8'h22, 1, 0, 0,   8'hFF, 1, 1, 3, 0, 0);
        add(8'h33, 1, 0, 0,   8'hFF, 1, 0, 4, 0, 0);
        add(8'h55, 1, 1, 0,   8'hEE, 1, 1, 3, 1, 0);  // full + pop: word dropped, ovf
        add(8'h00, 0, 1, 0,   8'hDD, 1, 1, 2, 1, 0);
        add(8'h00, 0, 1, 0,   8'hCC, 1, 1, 1, 1, 0);
        add(8'h00, 0, 1, 0,   8'h00, 0, 1, 0, 1, 0);  // 8'hAA never seen
        add(8'h00, 0, 0, 1,   8'h00, 0, 1, 0, 0, 0);  // clear ovf
        add(8'h00, 1, 1, 0,   8'hFF, 1, 1, 1, 0, 1);  // empty push + take: udf
        add(8'h00, 0, 1, 1,   8'h00, 0, 1, 0, 0, 0);  // clear udf with valid pop
        add(8'h00, 0, 1, 1,   8'h00, 0, 1, 0, 0, 1);  // set wins over clear
        add(8'h00, 0, 0, 1,   8'h00, 0, 1, 0, 0, 0);
        add(8'h0F, 1, 0, 0,   8'hF0, 1, 1, 1, 0, 0);
        add(8'h3C, 1, 1, 0,   8'hC3, 1, 1, 1, 0, 0);  // simultaneous push/pop
        add(8'h00, 0, 1, 0,   8'h00, 0, 1, 0, 0, 0);

        // Reset state while reset is held
        repeat (2) @(posedge clk);
        #1;
        check_all("in_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].din_b, vecs[i].din_val, vecs[i].dout_take, vecs[i].clr_err);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), int'(vecs[i].exp_dout), int'(vecs[i].exp_val),
                      int'(vecs[i].exp_rdy), vecs[i].exp_count, int'(vecs[i].exp_ovf),
                      int'(vecs[i].exp_udf));
        end

        // Mid-operation reset: fill to 2, assert reset between edges
        drive(8'h5A, 1, 0, 0);
        @(posedge clk);
        drive(8'hA5, 1, 0, 0);
        @(posedge clk);
        #1;
        check("pre_rst count", int'(bus.count), 2);
        drive(8'h00, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_rst", 0, 0, 1, 0, 0, 0);
        drive(8'hC3, 1, 0, 0);
        @(posedge clk);
        #1;
        check_all("post_rst push", 8'h3C, 1, 1, 1, 0, 0);
        drive(8'h00, 0, 1, 0);
        @(posedge clk);
        #1;
        check_all("post_rst pop", 0, 0, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
